// File: rtl/aging_uart_pkg.sv
// ============================================================================
// Module : aging_uart_pkg
// Brief  : Shared constants and parser state encoding for the aging UART link.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package aging_uart_pkg;

    localparam logic [7:0] HDR          = 8'hA5;
    localparam int         COUNT_WINDOW = 4;
    localparam int         N_MON        = 5;
    localparam int         FRAME_LEN    = 8;

    typedef enum logic [2:0] {
        PS_HUNT = 3'd0,
        PS_ALU0 = 3'd1,
        PS_ALU1 = 3'd2,
        PS_ALU2 = 3'd3,
        PS_IU0  = 3'd4,
        PS_IU1  = 3'd5,
        PS_IU2  = 3'd6,
        PS_CHK  = 3'd7
    } parse_state_t;

endpackage

`default_nettype wire

// File: rtl/aging_uart_rx_byte.sv
// ============================================================================
// Module : aging_uart_rx_byte
// Brief  : rxd synchroniser and 8N1 bit FSM; emits bytes and stop-bit errors.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aging_uart_rx_byte #(
    parameter int CLK_DIV = 87
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_rxd,
    output logic [7:0] o_byte,
    output logic       o_byte_valid,
    output logic       o_stop_err
);

    typedef enum logic [1:0] {
        BS_IDLE  = 2'd0,
        BS_START = 2'd1,
        BS_DATA  = 2'd2,
        BS_STOP  = 2'd3
    } bit_state_t;

    localparam int             CW          = $clog2(CLK_DIV);
    localparam logic [CW-1:0]  c_bit_last  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0]  c_half_last = CW'(CLK_DIV / 2 - 1);

    logic [1:0]    r_sync;
    logic          r_rxd_d;
    bit_state_t    r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          w_rxd;
    logic          w_fall;

    assign w_rxd  = r_sync[1];
    assign w_fall = r_rxd_d & ~w_rxd;

    // Preset to idle-high so reset release never looks like a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync  <= 2'b11;
            r_rxd_d <= 1'b1;
        end else begin
            r_sync  <= {r_sync[0], i_rxd};
            r_rxd_d <= w_rxd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= BS_IDLE;
            r_cnt        <= '0;
            r_bit        <= 3'd0;
            r_shift      <= 8'h00;
            o_byte       <= 8'h00;
            o_byte_valid <= 1'b0;
            o_stop_err   <= 1'b0;
        end else begin
            o_byte_valid <= 1'b0;
            o_stop_err   <= 1'b0;
            case (r_state)
                BS_IDLE: begin
                    r_cnt <= '0;
                    if (w_fall) r_state <= BS_START;
                end
                BS_START: begin
                    if (r_cnt == c_half_last) begin
                        r_cnt   <= '0;
                        r_bit   <= 3'd0;
                        r_state <= w_rxd ? BS_IDLE : BS_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                BS_DATA: begin
                    if (r_cnt == c_bit_last) begin
                        r_cnt   <= '0;
                        r_shift <= {w_rxd, r_shift[7:1]};
                        r_bit   <= r_bit + 3'd1;
                        if (r_bit == 3'd7) r_state <= BS_STOP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                BS_STOP: begin
                    if (r_cnt == c_bit_last) begin
                        r_cnt   <= '0;
                        r_state <= BS_IDLE;
                        if (w_rxd) begin
                            o_byte       <= r_shift;
                            o_byte_valid <= 1'b1;
                        end else begin
                            o_stop_err   <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= BS_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/aging_uart_rx.sv
// ============================================================================
// Module : aging_uart_rx
// Brief  : Aging telemetry frame receiver: byte parser, checksum, output regs.
//          Optional inter-byte timeout built when AGING_RX_TIMEOUT_EN is defined.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aging_uart_rx #(
    parameter int         CLK_DIV      = 87,
    parameter int         COUNT_WINDOW = aging_uart_pkg::COUNT_WINDOW,
    parameter int         N_MON        = aging_uart_pkg::N_MON,
    parameter logic [7:0] HDR          = aging_uart_pkg::HDR
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rxd,
    output logic [COUNT_WINDOW*N_MON-1:0] alu_aging_o,
    output logic [COUNT_WINDOW*N_MON-1:0] iu_aging_o,
    output logic                          frame_valid_o,
    output logic                          frame_err_o,
    output logic                          byte_valid_o,
    output logic [7:0]                    byte_o
);

    import aging_uart_pkg::*;

    localparam int W = COUNT_WINDOW * N_MON;

    logic [7:0]   w_byte;
    logic         w_byte_valid;
    logic         w_stop_err;
    logic         w_timeout;
    parse_state_t r_state;
    logic [W-1:0] r_alu;
    logic [W-1:0] r_iu;
    logic [7:0]   r_ck;

    aging_uart_rx_byte #(
        .CLK_DIV      (CLK_DIV)
    ) u_byte (
        .clk          (clk),
        .rst          (rst),
        .i_rxd        (rxd),
        .o_byte       (w_byte),
        .o_byte_valid (w_byte_valid),
        .o_stop_err   (w_stop_err)
    );

    assign byte_o       = w_byte;
    assign byte_valid_o = w_byte_valid;

`ifdef AGING_RX_TIMEOUT_EN
    localparam int            c_to_cyc = 16 * CLK_DIV;
    localparam int            TW       = $clog2(c_to_cyc + 1);
    localparam logic [TW-1:0] c_to_last = TW'(c_to_cyc - 1);

    logic [TW-1:0] r_to_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_cnt <= '0;
        end else if (w_byte_valid || (r_state == PS_HUNT)) begin
            r_to_cnt <= '0;
        end else if (r_to_cnt != c_to_last) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_state != PS_HUNT) && (r_to_cnt == c_to_last);
`else
    assign w_timeout = 1'b0;
`endif

    // A received byte always takes priority over a coincident timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= PS_HUNT;
            r_alu         <= '0;
            r_iu          <= '0;
            r_ck          <= 8'h00;
            alu_aging_o   <= '0;
            iu_aging_o    <= '0;
            frame_valid_o <= 1'b0;
            frame_err_o   <= 1'b0;
        end else begin
            frame_valid_o <= 1'b0;
            frame_err_o   <= 1'b0;
            if (w_stop_err) begin
                frame_err_o <= 1'b1;
                r_state     <= PS_HUNT;
            end else if (w_byte_valid) begin
                case (r_state)
                    PS_HUNT: if (w_byte == HDR) r_state <= PS_ALU0;
                    PS_ALU0: begin r_alu[7:0]    <= w_byte;          r_ck <= w_byte;        r_state <= PS_ALU1; end
                    PS_ALU1: begin r_alu[15:8]   <= w_byte;          r_ck <= r_ck ^ w_byte; r_state <= PS_ALU2; end
                    PS_ALU2: begin r_alu[W-1:16] <= w_byte[W-17:0];  r_ck <= r_ck ^ w_byte; r_state <= PS_IU0;  end
                    PS_IU0:  begin r_iu[7:0]     <= w_byte;          r_ck <= r_ck ^ w_byte; r_state <= PS_IU1;  end
                    PS_IU1:  begin r_iu[15:8]    <= w_byte;          r_ck <= r_ck ^ w_byte; r_state <= PS_IU2;  end
                    PS_IU2:  begin r_iu[W-1:16]  <= w_byte[W-17:0];  r_ck <= r_ck ^ w_byte; r_state <= PS_CHK;  end
                    PS_CHK: begin
                        if (w_byte == r_ck) begin
                            alu_aging_o   <= r_alu;
                            iu_aging_o    <= r_iu;
                            frame_valid_o <= 1'b1;
                        end else begin
                            frame_err_o   <= 1'b1;
                        end
                        r_state <= PS_HUNT;
                    end
                    default: r_state <= PS_HUNT;
                endcase
            end else if (w_timeout) begin
                frame_err_o <= 1'b1;
                r_state     <= PS_HUNT;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_aging_uart_rx.sv
// ============================================================================
// Module : tb_aging_uart_rx
// Brief  : Self-checking bench for aging_uart_rx with a byte-stream frame model.
// Rev    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_aging_uart_rx;

    localparam int         CLK_DIV = 87;
    localparam int         W       = 20;
    localparam logic [7:0] HDR     = 8'hA5;

    logic         clk = 1'b0;
    logic         rst;
    logic         rxd;
    logic [W-1:0] alu_aging_o;
    logic [W-1:0] iu_aging_o;
    logic         frame_valid_o;
    logic         frame_err_o;
    logic         byte_valid_o;
    logic [7:0]   byte_o;

    aging_uart_rx #(.CLK_DIV(CLK_DIV)) dut (
        .clk           (clk),
        .rst           (rst),
        .rxd           (rxd),
        .alu_aging_o   (alu_aging_o),
        .iu_aging_o    (iu_aging_o),
        .frame_valid_o (frame_valid_o),
        .frame_err_o   (frame_err_o),
        .byte_valid_o  (byte_valid_o),
        .byte_o        (byte_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Observed pulse counts, sampled on the falling edge.
    int n_fv = 0, n_fe = 0, n_bv = 0, n_both = 0;
    int cyc = 0, last_bv_cyc = -10;

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (byte_valid_o) begin
                n_bv++;
                last_bv_cyc = cyc;
            end
            if (frame_valid_o) begin
                n_fv++;
                check_val("fv_latency", 32'(cyc - last_bv_cyc), 32'd1);
            end
            if (frame_err_o) n_fe++;
            if (frame_valid_o && frame_err_o) n_both++;
        end
    end

    // Reference model: a stream of bytes, frames are HDR plus seven bytes.
    int           exp_fv = 0, exp_fe = 0, exp_bv = 0;
    logic [W-1:0] exp_alu = '0, exp_iu = '0;
    logic [7:0]   exp_byte = 8'h00;
    logic [7:0]   m_frame[$];

    task automatic model_byte(input logic [7:0] b, input logic stop_ok);
        logic [7:0] ck;
        if (!stop_ok) begin
            exp_fe++;
            m_frame.delete();
            return;
        end
        exp_bv++;
        exp_byte = b;
        if (m_frame.size() == 0) begin
            if (b == HDR) m_frame.push_back(b);
        end else begin
            m_frame.push_back(b);
            if (m_frame.size() == 8) begin
                ck = 8'h00;
                for (int i = 1; i <= 6; i++) ck ^= m_frame[i];
                if (ck == m_frame[7]) begin
                    exp_fv++;
                    exp_alu = {m_frame[3][3:0], m_frame[2], m_frame[1]};
                    exp_iu  = {m_frame[6][3:0], m_frame[5], m_frame[4]};
                end else begin
                    exp_fe++;
                end
                m_frame.delete();
            end
        end
    endtask

    task automatic model_idle(input int cycles);
`ifdef AGING_RX_TIMEOUT_EN
        if (m_frame.size() > 0 && cycles >= 16 * CLK_DIV) begin
            exp_fe++;
            m_frame.delete();
        end
`else
        if (cycles < 0) exp_fe++;
`endif
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        repeat (CLK_DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CLK_DIV) @(negedge clk);
        end
        rxd = stop;
        repeat (CLK_DIV) @(negedge clk);
        rxd = 1'b1;
        if (!stop) repeat (CLK_DIV) @(negedge clk);
        model_byte(b, stop);
    endtask

    task automatic send_frame(input logic [W-1:0] alu, input logic [W-1:0] iu,
                              input logic [3:0] pad_a, input logic [3:0] pad_i,
                              input logic ck_force, input logic [7:0] ck_val);
        logic [7:0] f[8];
        f[0] = HDR;
        f[1] = alu[7:0];
        f[2] = alu[15:8];
        f[3] = {pad_a, alu[19:16]};
        f[4] = iu[7:0];
        f[5] = iu[15:8];
        f[6] = {pad_i, iu[19:16]};
        f[7] = f[1] ^ f[2] ^ f[3] ^ f[4] ^ f[5] ^ f[6];
        if (ck_force) f[7] = ck_val;
        for (int i = 0; i < 8; i++) begin
            send_byte(f[i], 1'b1);
            repeat ($urandom_range(0, 60)) @(negedge clk);
        end
    endtask

    task automatic check_state(input string tag);
        repeat (5) @(negedge clk);
        check_val({tag, "_fv"},   32'(n_fv), 32'(exp_fv));
        check_val({tag, "_fe"},   32'(n_fe), 32'(exp_fe));
        check_val({tag, "_bv"},   32'(n_bv), 32'(exp_bv));
        check_val({tag, "_alu"},  32'(alu_aging_o), 32'(exp_alu));
        check_val({tag, "_iu"},   32'(iu_aging_o), 32'(exp_iu));
        check_val({tag, "_byte"}, 32'(byte_o), 32'(exp_byte));
    endtask

    task automatic model_reset();
        m_frame.delete();
        exp_alu  = '0;
        exp_iu   = '0;
        exp_byte = 8'h00;
    endtask

    initial begin
        repeat (150000) @(posedge clk);
        $display("FAIL watchdog: observed cycle limit expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] garbage[3];
        int         idle;
        garbage = '{8'h00, 8'hFF, 8'h5A};
        rst = 1'b1;
        rxd = 1'b1;
        repeat (10) @(negedge clk);
        check_val("reset_fv",  32'(frame_valid_o), 32'd0);
        check_val("reset_fe",  32'(frame_err_o), 32'd0);
        check_val("reset_alu", 32'(alu_aging_o), 32'd0);
        check_val("reset_byte", 32'(byte_o), 32'd0);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        // Directed good frame: A5 21 43 05 BA DC 0E CK
        send_frame(20'h54321, 20'hEDCBA, 4'h0, 4'h0, 1'b0, 8'h00);
        check_state("good");
        check_val("good_alu_lit", 32'(alu_aging_o), 32'h54321);
        check_val("good_iu_lit",  32'(iu_aging_o), 32'hEDCBA);

        // Same frame with a zero checksum: error, outputs hold.
        send_frame(20'h54321, 20'hEDCBA, 4'h0, 4'h0, 1'b1, 8'h00);
        check_state("badck");

        // Garbage ahead of the header.
        foreach (garbage[i]) send_byte(garbage[i], 1'b1);
        send_frame(20'(($urandom)), 20'($urandom), 4'($urandom), 4'($urandom), 1'b0, 8'h00);
        check_state("garbage");

        // Short low glitch is a false start.
        rxd = 1'b0;
        repeat (20) @(negedge clk);
        rxd = 1'b1;
        repeat (200) @(negedge clk);
        check_state("glitch");

        // Stop-bit error mid-frame returns the parser to hunting.
        send_byte(HDR, 1'b1);
        send_byte(8'h3C, 1'b0);
        send_frame(20'($urandom), 20'($urandom), 4'($urandom), 4'($urandom), 1'b0, 8'h00);
        check_state("stoperr");

        // Randomised frames; some carry HDR as payload, some a random checksum.
        for (int k = 0; k < 2; k++) begin
            logic [W-1:0] a;
            a = 20'($urandom);
            if (k == 0) a[7:0] = HDR;
            send_frame(a, 20'($urandom), 4'($urandom), 4'($urandom),
                       1'($urandom_range(0, 3) == 0), 8'($urandom));
            check_state("rand");
        end

        // Reset during the fourth byte of a frame.
        send_byte(HDR, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        rxd = 1'b0;
        repeat (CLK_DIV) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rxd = 1'($urandom);
            repeat (CLK_DIV) @(negedge clk);
        end
        rst = 1'b1;
        rxd = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (2 * CLK_DIV) @(negedge clk);
        check_state("abort");
        send_frame(20'($urandom), 20'($urandom), 4'($urandom), 4'($urandom), 1'b0, 8'h00);
        check_state("after_abort");

        // Partial frame followed by a long idle.
        send_byte(HDR, 1'b1);
        send_byte(8'h21, 1'b1);
        idle = 16 * CLK_DIV + 300;
        repeat (idle) @(negedge clk);
        model_idle(idle);
        check_state("idle");
        send_frame(20'($urandom), 20'($urandom), 4'($urandom), 4'($urandom), 1'b0, 8'h00);
        check_state("after_idle");

        check_val("both_pulses", 32'(n_both), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
